// File: rtl/lsu_bus_ctrl_if.sv
// Data-memory bus channel between the load/store sequencer and memory:
// a valid/ready request channel and a valid-only response channel.
interface lsu_bus_ctrl_if #(
  parameter int ADDR_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic              req_wen;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic [7:0]        req_wstrb;
  logic              resp_valid;
  logic [63:0]       resp_rdata;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    input  req_ready, resp_valid, resp_rdata
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
    output req_ready, resp_valid, resp_rdata
  );
endinterface

// File: rtl/lsu_bus_ctrl.sv
// Multi-cycle load/store sequencer: checks alignment, steers store bytes
// onto the doubleword bus, extends load data and stalls the pipeline until
// the bus access completes, is rejected as misaligned, or times out.
module lsu_bus_ctrl #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int ADDR_W         = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        load_type,
  input  logic [2:0]        store_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [63:0]       wdata,
  output logic              stall,
  output logic              done,
  output logic [63:0]       rdata,
  output logic              misalign,
  output logic              bus_err,
  lsu_bus_ctrl_if.master    bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t            state, state_n;
  logic [TW-1:0]     timer;
  logic              go, mis_now, sgn_in, timeout_hit;
  logic [1:0]        size_in;
  logic              fin_mis, fin_to, fin_resp, in_req;
  logic [ADDR_W-1:0] lat_addr;
  logic [63:0]       lat_wdata;
  logic [7:0]        lat_strb;
  logic [2:0]        lat_off;
  logic [1:0]        lat_size;
  logic              lat_sgn, lat_wen;

  // Byte-enable pattern for an access of 2**size bytes starting at lane off.
  function automatic logic [7:0] lane_strb(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] m;
    unique case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m << off;
  endfunction

  // Pull the addressed bytes out of the doubleword and sign/zero extend.
  function automatic logic [63:0] load_ext(input logic [63:0] raw, input logic [2:0] off,
                                           input logic [1:0] size, input logic sgn);
    logic [63:0]        lane;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    logic signed [63:0] sx;
    lane = raw >> {off, 3'b000};
    b    = lane[7:0];
    h    = lane[15:0];
    w    = lane[31:0];
    unique case (size)
      2'd0:    if (sgn) sx = b; else sx = {56'd0, lane[7:0]};
      2'd1:    if (sgn) sx = h; else sx = {48'd0, lane[15:0]};
      2'd2:    if (sgn) sx = w; else sx = {32'd0, lane[31:0]};
      default: sx = lane;
    endcase
    return sx;
  endfunction

  // Decode access size/signedness from the decoder types; a store wins over a load.
  always_comb begin
    size_in = 2'd0;
    sgn_in  = 1'b0;
    if (mem_write) begin
      unique case (store_type)
        3'b101:  size_in = 2'd1;
        3'b110:  size_in = 2'd2;
        3'b111:  size_in = 2'd3;
        default: size_in = 2'd0;
      endcase
    end else begin
      unique case (load_type)
        3'b001:  begin size_in = 2'd0; sgn_in = 1'b1; end
        3'b010:  begin size_in = 2'd1; sgn_in = 1'b1; end
        3'b011:  begin size_in = 2'd2; sgn_in = 1'b1; end
        3'b100:  size_in = 2'd3;
        3'b101:  size_in = 2'd0;
        3'b110:  size_in = 2'd1;
        3'b111:  size_in = 2'd2;
        default: size_in = 2'd0;
      endcase
    end
  end

  assign go          = ex_valid & (mem_read | mem_write);
  assign mis_now     = ((size_in == 2'd1) & addr[0]) |
                       ((size_in == 2'd2) & (addr[1:0] != 2'b00)) |
                       ((size_in == 2'd3) & (addr[2:0] != 3'b000));
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer >= TO_LAST);

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Next state and completion causes; a response in RESP beats a same-cycle timeout.
  always_comb begin
    state_n  = state;
    fin_mis  = 1'b0;
    fin_to   = 1'b0;
    fin_resp = 1'b0;
    unique case (state)
      IDLE: begin
        if (go) begin
          state_n = mis_now ? DONE : REQ;
          fin_mis = mis_now;
        end
      end
      REQ: begin
        if (timeout_hit) begin
          state_n = DONE;
          fin_to  = 1'b1;
        end else if (bus.req_ready) begin
          state_n = RESP;
        end
      end
      RESP: begin
        if (bus.resp_valid) begin
          state_n  = DONE;
          fin_resp = 1'b1;
        end else if (timeout_hit) begin
          state_n = DONE;
          fin_to  = 1'b1;
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Bus timer: cleared on issue, counts every cycle spent waiting on the bus.
  always_ff @(posedge clock) begin
    if (reset)                         timer <= '0;
    else if (state == IDLE && go)      timer <= '0;
    else if (state == REQ || state == RESP) timer <= timer + 1'b1;
  end

  // Capture the access when it is accepted; store data is lane-shifted here.
  always_ff @(posedge clock) begin
    if (state == IDLE && go) begin
      lat_addr  <= {addr[ADDR_W-1:3], 3'b000};
      lat_off   <= addr[2:0];
      lat_size  <= size_in;
      lat_sgn   <= sgn_in;
      lat_wen   <= mem_write;
      lat_wdata <= wdata << {addr[2:0], 3'b000};
      lat_strb  <= mem_write ? lane_strb(size_in, addr[2:0]) : 8'h00;
    end
  end

  // Completion results, held until the next completion.
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata    <= '0;
      misalign <= 1'b0;
      bus_err  <= 1'b0;
    end else if (fin_mis) begin
      rdata    <= '0;
      misalign <= 1'b1;
      bus_err  <= 1'b0;
    end else if (fin_to) begin
      rdata    <= '0;
      misalign <= 1'b0;
      bus_err  <= 1'b1;
    end else if (fin_resp) begin
      rdata    <= lat_wen ? 64'd0 : load_ext(bus.resp_rdata, lat_off, lat_size, lat_sgn);
      misalign <= 1'b0;
      bus_err  <= 1'b0;
    end
  end

  // Reset masks the bus and pipeline controls in the very cycle it is sampled.
  assign in_req        = (state == REQ) & ~reset;
  assign bus.req_valid = in_req;
  assign bus.req_wen   = in_req & lat_wen;
  assign bus.req_addr  = in_req ? lat_addr  : '0;
  assign bus.req_wdata = in_req ? lat_wdata : '0;
  assign bus.req_wstrb = in_req ? lat_strb  : '0;
  assign stall = ~reset & (((state == IDLE) & go) | (state == REQ) | (state == RESP));
  assign done  = ~reset & (state == DONE);

endmodule

// File: doc/lsu_bus_ctrl.md
Name: lsu_bus_ctrl

Overview:
- Multi-cycle load/store sequencer between decode/execute and the data-memory bus.
- Takes mem_read/mem_write and load_type/store_type from the decoder, plus the ALU-computed address and rs2 data.
- Drives a valid/ready request channel and a valid response channel, and stalls the pipeline until the access finishes.
- Also does alignment checking, byte-lane steering, write-strobe generation, load sign/zero extension and bus timeout detection.

Parameters:
- TIMEOUT_CYCLES, 256: cycles allowed from entering REQ to resp_valid before bus_err; 0 disables the timeout.
- ADDR_W, 64: address width.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- ex_valid  in  1  execute-stage instruction valid
- mem_read  in  1  load instruction
- mem_write  in  1  store instruction
- load_type  in  3  000 none, 001 lb, 010 lh, 011 lw, 100 ld, 101 lbu, 110 lhu, 111 lwu
- store_type  in  3  000 none, 100 sb, 101 sh, 110 sw, 111 sd
- addr  in  ADDR_W  effective byte address
- wdata  in  64  store data (rs2), LSB-aligned
- stall  out  1  holds the pipeline
- done  out  1  one-cycle completion pulse
- rdata  out  64  extended load result; valid when done=1
- misalign  out  1  with done: address misaligned, no bus access made
- bus_err  out  1  with done: timeout
- req_valid  out  1  bus request valid
- req_ready  in  1  bus accepts request
- req_wen  out  1  1 = write
- req_addr  out  ADDR_W  addr with bits [2:0] cleared
- req_wdata  out  64  lane-shifted store data
- req_wstrb  out  8  byte strobes; 0 for loads
- resp_valid  in  1  read data / write ack valid
- resp_rdata  in  64  aligned doubleword read data

Behaviour:
- Clocking: single clock, synchronous active-high reset.
- Access request: go = ex_valid & (mem_read | mem_write). If both mem_read and mem_write are set, the access is a store.
- State machine: states IDLE, REQ, RESP, DONE. Reset puts the FSM in IDLE.
- Reset values: every registered output and all bus outputs are 0. stall is forced to 0 while reset=1.
- IDLE:
  - If go: latch type, addr, wdata and off = addr[2:0].
  - Misaligned if (h-size & off[0]) | (w-size & off[1:0]!=0) | (d-size & off!=0). Misaligned goes to DONE with misalign=1; otherwise go to REQ and clear the timer.
  - resp_valid is ignored in IDLE.
- REQ:
  - req_valid=1; req_addr, req_wen, req_wdata and req_wstrb come from the latched values and stay stable while req_ready=0.
  - req_valid & req_ready moves to RESP.
- RESP:
  - req_valid=0.
  - On resp_valid: capture the extended data for loads, or 0 for stores, then go to DONE.
  - A same-cycle ready/response in REQ is not sampled; the response is taken in RESP only.
- DONE: done=1 for one cycle, stall=0, then IDLE. go is not re-evaluated in DONE, because the same instruction is still presented that cycle.
- stall = (IDLE & go) | REQ | RESP.
- Minimum latency: go in cycle 0 → REQ in cycle 1 (ready=1) → RESP in cycle 2 (resp_valid=1) → done in cycle 3.
- Timer: increments each cycle in REQ/RESP. When it reaches TIMEOUT_CYCLES (nonzero), go to DONE with bus_err=1 and rdata=0. An outstanding request is abandoned and a late response arrives in IDLE, where it is ignored.
- Store steering:
  - req_wdata = wdata << (8*off).
  - req_wstrb: sb 8'h01<<off, sh 8'h03<<off, sw 8'h0F<<off, sd 8'hFF.
- Load extraction:
  - Source bytes are resp_rdata[8*off +: N].
  - lb/lh/lw sign-extend; lbu/lhu/lwu zero-extend; ld passes through.
- Outputs outside DONE: misalign, bus_err and rdata hold their last value; they are meaningful only when done=1.
- Reset mid-operation: the FSM returns to IDLE immediately and req_valid drops in the same cycle reset is sampled. A pending response is discarded.

Test Plan:
- ld addr 0x80000008, req_ready=1, resp_valid two cycles after handshake with 0x1122334455667788:
  - req_addr=0x80000008, req_wen=0, req_wstrb=0x00.
  - done with rdata=0x1122334455667788 and misalign=0, bus_err=0.
  - stall high from the go cycle until done.
- lb addr 0x80000003, resp_rdata=0x0000000080000000: rdata=0xFFFFFFFFFFFFFF80. Repeat as lbu: rdata=0x0000000000000080.
- sh addr 0x80000006, wdata=0xABCD, req_ready held 0 for 3 cycles:
  - req_valid stays high with stable req_addr=0x80000000, req_wdata=0xABCD000000000000, req_wstrb=0xC0.
  - The write ack via resp_valid gives done.
- sw addr 0x80000002: no req_valid ever; next cycle done=1, misalign=1, stall is 0 in DONE.
- TIMEOUT_CYCLES=16, ld with req_ready=0 forever: done=1, bus_err=1, rdata=0 after 16 timer cycles. A later stray resp_valid in IDLE has no effect.
- reset pulsed during RESP of an ld, then resp_valid arrives:
  - FSM in IDLE, all outputs 0, response ignored.
  - A following ld completes normally with correct data.
